tictactoe_move_driver: RTL and testbench

TICTACTOE_MOVE_DRIVER -- requirements
Module: tictactoe_move_driver

---
 rtl/tictactoe_pkg.sv | 43 ++++
 rtl/tictactoe_line_eval.sv | 29 ++
 rtl/tictactoe_move_driver.sv | 229 ++++++++++++++++++++++
 tb/tb_tictactoe_move_driver.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tictactoe_pkg.sv
// Shared encodings, line table and FSM states for the tic-tac-toe move driver.
package tictactoe_pkg;

   // Board cell codes
   localparam logic [1:0] CELL_EMPTY  = 2'b00;
   localparam logic [1:0] CELL_PLAYER = 2'b01;
   localparam logic [1:0] CELL_PC     = 2'b10;

   // Game result codes reported by the game core
   localparam logic [1:0] WHO_RUN  = 2'b00;
   localparam logic [1:0] WHO_PWIN = 2'b01;
   localparam logic [1:0] WHO_CWIN = 2'b10;
   localparam logic [1:0] WHO_DRAW = 2'b11;

   // Eight winning lines, three cell indices each, first cell in the top nibble.
   // Order: rows 0-2, columns 0-2, diagonal 0/4/8, diagonal 2/4/6.
   localparam int unsigned NUM_LINES = 8;
   localparam logic [11:0] LINE_TABLE [NUM_LINES] = '{
      12'h012, 12'h345, 12'h678,
      12'h036, 12'h147, 12'h258,
      12'h048, 12'h246
   };

   typedef enum logic [2:0] {
      IDLE,
      P_STROBE,
      P_WAIT,
      SCAN,
      C_STROBE,
      C_WAIT,
      GAME_OVER
   } state_t;

   // Pick one cell index (offset 0..2) out of a packed line entry.
   function automatic logic [3:0] line_cell(input logic [11:0] line, input logic [1:0] off);
      case (off)
         2'd0:    line_cell = line[11:8];
         2'd1:    line_cell = line[7:4];
         default: line_cell = line[3:0];
      endcase
   endfunction

endpackage

// File: rtl/tictactoe_line_eval.sv
// Combinational evaluation of one board line: win / block candidate and empty slot.
module tictactoe_line_eval
   import tictactoe_pkg::*;
(
   input  logic [1:0] cell_a,
   input  logic [1:0] cell_b,
   input  logic [1:0] cell_c,
   output logic       win_hit,
   output logic       block_hit,
   output logic [1:0] empty_off
);

   logic [1:0] w_n_pc;
   logic [1:0] w_n_pl;
   logic [1:0] w_n_em;

   assign w_n_pc = 2'({1'b0, cell_a == CELL_PC}) + 2'({1'b0, cell_b == CELL_PC})
                 + 2'({1'b0, cell_c == CELL_PC});
   assign w_n_pl = 2'({1'b0, cell_a == CELL_PLAYER}) + 2'({1'b0, cell_b == CELL_PLAYER})
                 + 2'({1'b0, cell_c == CELL_PLAYER});
   assign w_n_em = 2'({1'b0, cell_a == CELL_EMPTY}) + 2'({1'b0, cell_b == CELL_EMPTY})
                 + 2'({1'b0, cell_c == CELL_EMPTY});

   assign win_hit   = (w_n_pc == 2'd2) && (w_n_em == 2'd1);
   assign block_hit = (w_n_pl == 2'd2) && (w_n_em == 2'd1);
   assign empty_off = (cell_a == CELL_EMPTY) ? 2'd0 :
                      (cell_b == CELL_EMPTY) ? 2'd1 : 2'd2;

endmodule

// File: rtl/tictactoe_move_driver.sv
// Sequences player and computer moves into the game core, choosing the computer
// move by scanning the eight board lines one per cycle.
module tictactoe_move_driver
   import tictactoe_pkg::*;
#(
   parameter int unsigned PLAY_HOLD  = 5,
   parameter int unsigned WAIT_LIMIT = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [3:0] key_pos,
   input  logic [1:0] pos1,
   input  logic [1:0] pos2,
   input  logic [1:0] pos3,
   input  logic [1:0] pos4,
   input  logic [1:0] pos5,
   input  logic [1:0] pos6,
   input  logic [1:0] pos7,
   input  logic [1:0] pos8,
   input  logic [1:0] pos9,
   input  logic [1:0] who,
   output logic       play,
   output logic [3:0] player_pos,
   output logic       pc,
   output logic [3:0] pc_pos,
   output logic       busy,
   output logic       key_reject,
   output logic       err,
   output logic       game_over
);

   localparam int unsigned CNT_MAX = (PLAY_HOLD > WAIT_LIMIT) ? PLAY_HOLD : WAIT_LIMIT;
   localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(PLAY_HOLD - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_LIMIT - 1);

   state_t           r_state, w_nxt_state;
   logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
   logic [2:0]       r_line, w_nxt_line;
   logic [3:0]       r_player_pos, w_nxt_player_pos;
   logic [3:0]       r_pc_pos, w_nxt_pc_pos;
   logic             r_win_vld, w_nxt_win_vld;
   logic [3:0]       r_win_pos, w_nxt_win_pos;
   logic             r_blk_vld, w_nxt_blk_vld;
   logic [3:0]       r_blk_pos, w_nxt_blk_pos;
   logic             r_key_reject, w_nxt_key_reject;
   logic             r_err, w_nxt_err;

   logic [1:0]  w_cells [16];
   logic [11:0] w_line;
   logic [3:0]  w_line_pos;
   logic        w_win_hit, w_blk_hit;
   logic [1:0]  w_empty_off;
   logic        w_any_empty;
   logic [3:0]  w_low_empty;

   // Board view indexable by a 4-bit position; indices 9..15 read as occupied
   always_comb begin
      for (int unsigned i = 0; i < 16; i++) w_cells[i] = 2'b11;
      w_cells[0] = pos1;
      w_cells[1] = pos2;
      w_cells[2] = pos3;
      w_cells[3] = pos4;
      w_cells[4] = pos5;
      w_cells[5] = pos6;
      w_cells[6] = pos7;
      w_cells[7] = pos8;
      w_cells[8] = pos9;
   end

   assign w_line = LINE_TABLE[r_line];

   tictactoe_line_eval u_line_eval (
      .cell_a    (w_cells[w_line[11:8]]),
      .cell_b    (w_cells[w_line[7:4]]),
      .cell_c    (w_cells[w_line[3:0]]),
      .win_hit   (w_win_hit),
      .block_hit (w_blk_hit),
      .empty_off (w_empty_off)
   );

   assign w_line_pos = line_cell(w_line, w_empty_off);

   // Lowest-index empty cell, fallback choice when no line candidate exists
   always_comb begin
      w_any_empty = 1'b0;
      w_low_empty = '0;
      for (int unsigned i = 0; i < 9; i++) begin
         if (!w_any_empty && w_cells[i] == CELL_EMPTY) begin
            w_any_empty = 1'b1;
            w_low_empty = 4'(i);
         end
      end
   end

   // Next-state and next-datapath logic
   always_comb begin
      w_nxt_state      = r_state;
      w_nxt_cnt        = r_cnt;
      w_nxt_line       = r_line;
      w_nxt_player_pos = r_player_pos;
      w_nxt_pc_pos     = r_pc_pos;
      w_nxt_win_vld    = r_win_vld;
      w_nxt_win_pos    = r_win_pos;
      w_nxt_blk_vld    = r_blk_vld;
      w_nxt_blk_pos    = r_blk_pos;
      w_nxt_key_reject = 1'b0;
      w_nxt_err        = 1'b0;
      case (r_state)
         IDLE: begin
            if (key_valid) begin
               if (who != WHO_RUN) begin
                  w_nxt_key_reject = 1'b1;
                  w_nxt_state      = GAME_OVER;
               end else if (key_pos > 4'd8 || w_cells[key_pos] != CELL_EMPTY) begin
                  w_nxt_key_reject = 1'b1;
               end else begin
                  w_nxt_player_pos = key_pos;
                  w_nxt_cnt        = '0;
                  w_nxt_state      = P_STROBE;
               end
            end
         end
         P_STROBE: begin
            if (r_cnt == HOLD_LAST) begin
               w_nxt_cnt   = '0;
               w_nxt_state = P_WAIT;
            end else begin
               w_nxt_cnt = r_cnt + 1'b1;
            end
         end
         P_WAIT: begin
            if (w_cells[r_player_pos] == CELL_PLAYER) begin
               w_nxt_cnt     = '0;
               w_nxt_line    = '0;
               w_nxt_win_vld = 1'b0;
               w_nxt_blk_vld = 1'b0;
               w_nxt_state   = (who != WHO_RUN) ? GAME_OVER : SCAN;
            end else if (r_cnt == WAIT_LAST) begin
               w_nxt_cnt   = '0;
               w_nxt_err   = 1'b1;
               w_nxt_state = IDLE;
            end else begin
               w_nxt_cnt = r_cnt + 1'b1;
            end
         end
         SCAN: begin
            // Candidates include the current line so the last scan cycle can decide
            w_nxt_win_vld = r_win_vld | w_win_hit;
            w_nxt_win_pos = (!r_win_vld && w_win_hit) ? w_line_pos : r_win_pos;
            w_nxt_blk_vld = r_blk_vld | w_blk_hit;
            w_nxt_blk_pos = (!r_blk_vld && w_blk_hit) ? w_line_pos : r_blk_pos;
            if (r_line == 3'd7) begin
               w_nxt_cnt   = '0;
               w_nxt_state = C_STROBE;
               if (w_nxt_win_vld)                  w_nxt_pc_pos = w_nxt_win_pos;
               else if (w_nxt_blk_vld)             w_nxt_pc_pos = w_nxt_blk_pos;
               else if (w_cells[4] == CELL_EMPTY)  w_nxt_pc_pos = 4'd4;
               else if (w_any_empty)               w_nxt_pc_pos = w_low_empty;
               else                                w_nxt_state  = GAME_OVER;
            end else begin
               w_nxt_line = r_line + 3'd1;
            end
         end
         C_STROBE: begin
            if (r_cnt == HOLD_LAST) begin
               w_nxt_cnt   = '0;
               w_nxt_state = C_WAIT;
            end else begin
               w_nxt_cnt = r_cnt + 1'b1;
            end
         end
         C_WAIT: begin
            if (w_cells[r_pc_pos] == CELL_PC) begin
               w_nxt_cnt   = '0;
               w_nxt_state = (who != WHO_RUN) ? GAME_OVER : IDLE;
            end else if (r_cnt == WAIT_LAST) begin
               w_nxt_cnt   = '0;
               w_nxt_err   = 1'b1;
               w_nxt_state = IDLE;
            end else begin
               w_nxt_cnt = r_cnt + 1'b1;
            end
         end
         GAME_OVER: w_nxt_state = GAME_OVER;
         default:   w_nxt_state = IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_line       <= '0;
         r_player_pos <= '0;
         r_pc_pos     <= '0;
         r_win_vld    <= 1'b0;
         r_win_pos    <= '0;
         r_blk_vld    <= 1'b0;
         r_blk_pos    <= '0;
         r_key_reject <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_nxt_state;
         r_cnt        <= w_nxt_cnt;
         r_line       <= w_nxt_line;
         r_player_pos <= w_nxt_player_pos;
         r_pc_pos     <= w_nxt_pc_pos;
         r_win_vld    <= w_nxt_win_vld;
         r_win_pos    <= w_nxt_win_pos;
         r_blk_vld    <= w_nxt_blk_vld;
         r_blk_pos    <= w_nxt_blk_pos;
         r_key_reject <= w_nxt_key_reject;
         r_err        <= w_nxt_err;
      end
   end

   assign play       = (r_state == P_STROBE);
   assign pc         = (r_state == C_STROBE);
   assign busy       = (r_state != IDLE);
   assign game_over  = (r_state == GAME_OVER);
   assign player_pos = r_player_pos;
   assign pc_pos     = r_pc_pos;
   assign key_reject = r_key_reject;
   assign err        = r_err;

endmodule

// File: tb/tb_tictactoe_move_driver.sv
// Self-checking bench: directed vector table, hand sequences and random games
// against a line-counting reference of the move rules.
module tb_tictactoe_move_driver;

   localparam int unsigned PLAY_HOLD  = 5;
   localparam int unsigned WAIT_LIMIT = 16;

   logic       clock = 1'b0;
   logic       reset;
   logic       key_valid;
   logic [3:0] key_pos;
   logic [1:0] who;
   logic [1:0] bd [9];
   logic       play, pc, busy, key_reject, err, game_over;
   logic [3:0] player_pos, pc_pos;

   int n_cmp = 0;
   int n_bad = 0;

   int LN [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                     '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

   typedef struct {
      string b;
      int    key;
      bit    force_run;
      bit    rej;
      bit    pcv;
      int    pcx;
      bit    over;
   } vec_t;

   vec_t tbl [10];

   always #5 clock = ~clock;

   tictactoe_move_driver #(.PLAY_HOLD(PLAY_HOLD), .WAIT_LIMIT(WAIT_LIMIT)) dut (
      .clock(clock), .reset(reset), .key_valid(key_valid), .key_pos(key_pos),
      .pos1(bd[0]), .pos2(bd[1]), .pos3(bd[2]), .pos4(bd[3]), .pos5(bd[4]),
      .pos6(bd[5]), .pos7(bd[6]), .pos8(bd[7]), .pos9(bd[8]), .who(who),
      .play(play), .player_pos(player_pos), .pc(pc), .pc_pos(pc_pos),
      .busy(busy), .key_reject(key_reject), .err(err), .game_over(game_over)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clock);
      check("play_pc_exclusive", {31'b0, play & pc}, 0);
   endtask

   // Winner of a board: full line of one code, else draw when full
   function automatic logic [1:0] ref_winner(input logic [1:0] b [9]);
      int empties = 0;
      for (int l = 0; l < 8; l++) begin
         if (b[LN[l][0]] == 2'b01 && b[LN[l][1]] == 2'b01 && b[LN[l][2]] == 2'b01) return 2'b01;
         if (b[LN[l][0]] == 2'b10 && b[LN[l][1]] == 2'b10 && b[LN[l][2]] == 2'b10) return 2'b10;
      end
      for (int i = 0; i < 9; i++) if (b[i] == 2'b00) empties++;
      return (empties == 0) ? 2'b11 : 2'b00;
   endfunction

   // Computer choice: first winning line, first blocking line, centre, lowest empty
   function automatic int ref_pick(input logic [1:0] b [9]);
      int win = -1, blk = -1;
      for (int l = 0; l < 8; l++) begin
         int np = 0, nc = 0, ne = 0, e = -1;
         for (int k = 0; k < 3; k++) begin
            case (b[LN[l][k]])
               2'b01:   np++;
               2'b10:   nc++;
               2'b00:   begin ne++; if (e < 0) e = LN[l][k]; end
               default: ;
            endcase
         end
         if (win < 0 && nc == 2 && ne == 1) win = e;
         if (blk < 0 && np == 2 && ne == 1) blk = e;
      end
      if (win >= 0) return win;
      if (blk >= 0) return blk;
      if (b[4] == 2'b00) return 4;
      for (int i = 0; i < 9; i++) if (b[i] == 2'b00) return i;
      return -1;
   endfunction

   task automatic load(input string s);
      for (int i = 0; i < 9; i++)
         bd[i] = (s[i] == "P") ? 2'b01 : (s[i] == "C") ? 2'b10 : 2'b00;
   endtask

   task automatic do_reset();
      reset = 1'b0; key_valid = 1'b0; key_pos = '0; who = 2'b00;
      for (int i = 0; i < 9; i++) bd[i] = 2'b00;
      repeat (3) tick();
      reset = 1'b1;
      tick();
   endtask

   // One player request with the game core modelled inline; caller sits on a negedge
   task automatic run_move(input int p, input bit force_run, input bit exp_rej,
                           input bit exp_pcv, input int exp_pc, input bit exp_over);
      int n;
      bit saw;
      key_pos = 4'(p); key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      if (exp_rej) begin
         check("reject_pulse", key_reject, 1);
         check("reject_no_play", play, 0);
         tick();
         check("reject_clear", key_reject, 0);
         check("reject_idle", busy, 0);
         return;
      end
      check("accept_no_reject", key_reject, 0);
      check("play_on", play, 1);
      check("player_pos", player_pos, p);
      n = 0;
      while (play === 1'b1 && n < 50) begin n++; tick(); end
      check("play_len", n, PLAY_HOLD);
      bd[p] = 2'b01;
      who = force_run ? 2'b00 : ref_winner(bd);
      if (who != 2'b00) begin
         tick();
         check("player_end_over", game_over, 1);
         check("player_end_no_pc", pc, 0);
         return;
      end
      if (!exp_pcv) begin
         saw = 1'b0;
         repeat (10) begin tick(); if (pc) saw = 1'b1; end
         check("full_no_pc", saw, 0);
         check("full_over", game_over, 1);
         return;
      end
      n = 0;
      while (pc !== 1'b1 && n < 40) begin n++; tick(); end
      check("scan_latency", n, 9);
      check("pc_pos", pc_pos, exp_pc);
      n = 0;
      while (pc === 1'b1 && n < 50) begin n++; tick(); end
      check("pc_len", n, PLAY_HOLD);
      bd[exp_pc] = 2'b10;
      who = force_run ? 2'b00 : ref_winner(bd);
      tick();
      check("after_pc_over", game_over, exp_over);
      check("after_pc_busy", busy, exp_over);
      check("pc_pos_hold", pc_pos, exp_pc);
   endtask

   initial begin
      int n;
      tbl[0] = '{".........", 9, 1'b0, 1'b1, 1'b0, 0, 1'b0};
      tbl[1] = '{"P........", 0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
      tbl[2] = '{".........", 0, 1'b0, 1'b0, 1'b1, 4, 1'b0};
      tbl[3] = '{"PP..C....", 8, 1'b0, 1'b0, 1'b1, 2, 1'b0};
      tbl[4] = '{".PP.C...C", 3, 1'b0, 1'b0, 1'b1, 0, 1'b1};
      tbl[5] = '{"PP.CC....", 8, 1'b0, 1'b0, 1'b1, 5, 1'b1};
      tbl[6] = '{"....C....", 0, 1'b0, 1'b0, 1'b1, 1, 1'b0};
      tbl[7] = '{"PCPPCCCP.", 8, 1'b1, 1'b0, 1'b0, 0, 1'b1};
      tbl[8] = '{"PCPPCCCP.", 8, 1'b0, 1'b0, 1'b0, 0, 1'b1};
      tbl[9] = '{"PP.CC....", 2, 1'b0, 1'b0, 1'b0, 0, 1'b1};

      // Reset values after three low cycles, then an out-of-range key
      reset = 1'b0; key_valid = 1'b0; key_pos = '0; who = 2'b00;
      for (int i = 0; i < 9; i++) bd[i] = 2'b00;
      repeat (3) tick();
      check("rst_play", play, 0);
      check("rst_pc", pc, 0);
      check("rst_busy", busy, 0);
      check("rst_key_reject", key_reject, 0);
      check("rst_err", err, 0);
      check("rst_game_over", game_over, 0);
      check("rst_player_pos", player_pos, 0);
      check("rst_pc_pos", pc_pos, 0);
      reset = 1'b1;
      tick();
      run_move(9, 1'b0, 1'b1, 1'b0, 0, 1'b0);

      // Vector table
      for (int v = 0; v < 10; v++) begin
         do_reset();
         load(tbl[v].b);
         run_move(tbl[v].key, tbl[v].force_run, tbl[v].rej, tbl[v].pcv, tbl[v].pcx, tbl[v].over);
      end

      // Request while the game is already decided, then ignored keys in GAME_OVER
      do_reset();
      who = 2'b10;
      key_pos = 4'd3; key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      check("over_req_reject", key_reject, 1);
      tick();
      check("over_state", game_over, 1);
      check("over_reject_clear", key_reject, 0);
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      check("over_key_ignored", key_reject, 0);
      who = 2'b00;
      repeat (4) tick();
      check("over_sticky", game_over, 1);
      check("over_busy", busy, 1);

      // Player cell never updates: timeout, with a stray key during the wait
      do_reset();
      key_pos = 4'd4; key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      n = 0;
      while (play === 1'b1 && n < 50) begin n++; tick(); end
      check("to_play_len", n, PLAY_HOLD);
      key_pos = 4'd9; key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      check("busy_key_ignored", key_reject, 0);
      repeat (14) tick();
      check("to_err_early", err, 0);
      check("to_busy_early", busy, 1);
      tick();
      check("to_err_pulse", err, 1);
      check("to_idle", busy, 0);
      tick();
      check("to_err_clear", err, 0);

      // Reset during the computer strobe
      do_reset();
      key_pos = 4'd0; key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      n = 0;
      while (play === 1'b1 && n < 50) begin n++; tick(); end
      bd[0] = 2'b01;
      n = 0;
      while (pc !== 1'b1 && n < 40) begin n++; tick(); end
      check("mid_pc_seen", pc, 1);
      check("mid_pc_pos", pc_pos, 4);
      reset = 1'b0;
      tick();
      check("mid_rst_pc", pc, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_pc_pos", pc_pos, 0);
      reset = 1'b1;
      tick();

      // Random games against the reference rules
      for (int g = 0; g < 25; g++) begin
         bit over;
         do_reset();
         over = 1'b0;
         for (int m = 0; m < 12 && !over; m++) begin
            logic [1:0] tmp [9];
            int q [$];
            int k, pcx;
            bit rej, pcv, fin;
            logic [1:0] w;
            for (int i = 0; i < 9; i++) if (bd[i] == 2'b00) q.push_back(i);
            if ($urandom_range(0, 4) == 0 || q.size() == 0) k = int'($urandom_range(0, 15));
            else k = q[$urandom_range(0, q.size() - 1)];
            rej = (k > 8) || (bd[k] != 2'b00);
            pcv = 1'b0; pcx = 0; fin = 1'b0;
            if (!rej) begin
               tmp = bd;
               tmp[k] = 2'b01;
               w = ref_winner(tmp);
               if (w != 2'b00) fin = 1'b1;
               else begin
                  pcx = ref_pick(tmp);
                  pcv = (pcx >= 0);
                  if (pcv) begin
                     tmp[pcx] = 2'b10;
                     fin = (ref_winner(tmp) != 2'b00);
                  end else fin = 1'b1;
               end
            end
            run_move(k, 1'b0, rej, pcv, pcx, fin);
            over = fin;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
